wbf_rd_buf: RTL and testbench



---
 rtl/wbf_pkg.sv | 24 ++
 rtl/wbf_rd_buf_if.sv | 31 +++
 rtl/wbf_sram.sv | 25 ++
 rtl/wbf_rd_buf.sv | 136 +++++++++++++
 tb/tb_wbf_rd_buf.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbf_pkg.sv
// Weight buffer shared constants, FSM state type and config clamp helper.
package wbf_pkg;

   localparam int unsigned DATA_WIDTH     = 8;
   localparam int unsigned WEI_ADDR_WIDTH = 8;
   localparam int unsigned DEPTH          = 2 ** WEI_ADDR_WIDTH;
   localparam int unsigned NUM_W          = WEI_ADDR_WIDTH + 1;
   localparam int unsigned OFIFO_DEPTH    = 2;
   localparam int unsigned OFIFO_CNT_W    = 2;
   localparam int unsigned CREDIT_W       = 3;
   localparam int unsigned WBF_STATE_W    = 2;

   typedef enum logic [WBF_STATE_W-1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      WORK = 2'd2
   } wbf_state_e;

   // Requests beyond the physical depth fill the whole array.
   function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] num);
      return (num > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : num;
   endfunction

endpackage

// File: rtl/wbf_rd_buf_if.sv
// Config, GLB fill and WCA read handshakes of the weight buffer.
interface wbf_rd_buf_if
   import wbf_pkg::*;
();

   logic                      TOPWBF_CfgVld;
   logic [NUM_W-1:0]          TOPWBF_CfgNum;
   logic                      WBFTOP_CfgRdy;
   logic                      GLBWBF_DatVld;
   logic [DATA_WIDTH-1:0]     GLBWBF_Dat;
   logic                      WBFGLB_DatRdy;
   logic                      WCAWBF_AdrVld;
   logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr;
   logic                      WBFWCA_AdrRdy;
   logic                      WBFWCA_DatVld;
   logic [DATA_WIDTH-1:0]     WBFWCA_Dat;
   logic                      WCAWBF_DatRdy;

   modport slave (
      input  TOPWBF_CfgVld, TOPWBF_CfgNum, GLBWBF_DatVld, GLBWBF_Dat,
             WCAWBF_AdrVld, WCAWBF_Adr, WCAWBF_DatRdy,
      output WBFTOP_CfgRdy, WBFGLB_DatRdy, WBFWCA_AdrRdy, WBFWCA_DatVld, WBFWCA_Dat
   );

   modport master (
      output TOPWBF_CfgVld, TOPWBF_CfgNum, GLBWBF_DatVld, GLBWBF_Dat,
             WCAWBF_AdrVld, WCAWBF_Adr, WCAWBF_DatRdy,
      input  WBFTOP_CfgRdy, WBFGLB_DatRdy, WBFWCA_AdrRdy, WBFWCA_DatVld, WBFWCA_Dat
   );

endinterface

// File: rtl/wbf_sram.sv
// Behavioural 1RW weight SRAM with one-cycle registered read; replaced by the foundry macro.
module wbf_sram
   import wbf_pkg::*;
(
   input  logic                      clk,
   input  logic                      en,
   input  logic                      we,
   input  logic [WEI_ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH-1:0]     rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) r_mem[addr] <= wdata;
         else    r_rdata     <= r_mem[addr];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/wbf_rd_buf.sv
// Weight buffer: fills SRAM from the GLB, then serves in-order WCA reads through a 2-entry skid FIFO.
module wbf_rd_buf
   import wbf_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   wbf_rd_buf_if.slave  bus
);

   wbf_state_e                r_state;
   wbf_state_e                w_state_nxt;
   logic                      r_live;
   logic [NUM_W-1:0]          r_num;
   logic [WEI_ADDR_WIDTH-1:0] r_wr_ptr;
   logic                      r_inflight;
   logic [WEI_ADDR_WIDTH-1:0] r_rd_adr;
   logic [DATA_WIDTH-1:0]     r_fifo [OFIFO_DEPTH];
   logic                      r_wp;
   logic                      r_rp;
   logic [OFIFO_CNT_W-1:0]    r_cnt;

   logic                      w_cfg_rdy;
   logic                      w_dat_rdy;
   logic                      w_adr_rdy;
   logic                      w_dat_vld;
   logic                      w_cfg_hs;
   logic                      w_fill_hs;
   logic                      w_adr_hs;
   logic                      w_pop;
   logic [CREDIT_W-1:0]       w_credit;
   logic [NUM_W-1:0]          w_num_new;
   logic                      w_sram_en;
   logic [WEI_ADDR_WIDTH-1:0] w_sram_addr;
   logic [DATA_WIDTH-1:0]     w_rdata;
   logic [DATA_WIDTH-1:0]     w_push_dat;

   assign w_dat_vld = (r_cnt != '0);
   assign w_pop     = w_dat_vld & bus.WCAWBF_DatRdy;
   assign w_num_new = clamp_num(bus.TOPWBF_CfgNum);
   // Occupied slots (FIFO + read in flight) net of this cycle's pop; at most 2 may be owed.
   assign w_credit  = CREDIT_W'(r_cnt) + CREDIT_W'(r_inflight) - CREDIT_W'(w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and handshake readies; r_live keeps CfgRdy low while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_cfg_rdy   = 1'b0;
      w_dat_rdy   = 1'b0;
      w_adr_rdy   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cfg_rdy = r_live;
            if (bus.TOPWBF_CfgVld && r_live)
               w_state_nxt = (w_num_new == '0) ? WORK : FILL;
         end
         FILL: begin
            w_dat_rdy = 1'b1;
            if (bus.GLBWBF_DatVld && ({1'b0, r_wr_ptr} == r_num - NUM_W'(1)))
               w_state_nxt = WORK;
         end
         WORK: begin
            w_adr_rdy = (w_credit < CREDIT_W'(2));
            w_cfg_rdy = !r_inflight && (r_cnt == '0);
            if (bus.TOPWBF_CfgVld && w_cfg_rdy)
               w_state_nxt = (w_num_new == '0) ? WORK : FILL;
         end
         default: w_state_nxt = IDLE;
      endcase
      w_cfg_hs  = bus.TOPWBF_CfgVld & w_cfg_rdy;
      w_fill_hs = bus.GLBWBF_DatVld & w_dat_rdy;
      w_adr_hs  = bus.WCAWBF_AdrVld & w_adr_rdy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live     <= 1'b0;
         r_num      <= '0;
         r_wr_ptr   <= '0;
         r_inflight <= 1'b0;
         r_rd_adr   <= '0;
      end else begin
         r_live     <= 1'b1;
         r_inflight <= w_adr_hs;
         if (w_adr_hs) r_rd_adr <= bus.WCAWBF_Adr;
         if (w_cfg_hs) begin
            r_num    <= w_num_new;
            r_wr_ptr <= '0;
         end else if (w_fill_hs) begin
            r_wr_ptr <= r_wr_ptr + WEI_ADDR_WIDTH'(1);
         end
      end
   end

   // Only one of FILL/WORK is active, so the single port never sees a write and read together.
   assign w_sram_en   = w_fill_hs | w_adr_hs;
   assign w_sram_addr = (r_state == FILL) ? r_wr_ptr : bus.WCAWBF_Adr;

   wbf_sram u_sram (
      .clk   (clk),
      .en    (w_sram_en),
      .we    (w_fill_hs),
      .addr  (w_sram_addr),
      .wdata (bus.GLBWBF_Dat),
      .rdata (w_rdata)
   );

   assign w_push_dat = ({1'b0, r_rd_adr} >= r_num) ? '0 : w_rdata;

   // Output FIFO: push when the registered read returns, pop on WCA handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(OFIFO_DEPTH); i++) r_fifo[i] <= '0;
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= '0;
      end else begin
         if (r_inflight) begin
            r_fifo[r_wp] <= w_push_dat;
            r_wp         <= ~r_wp;
         end
         if (w_pop) r_rp <= ~r_rp;
         r_cnt <= r_cnt + OFIFO_CNT_W'(r_inflight) - OFIFO_CNT_W'(w_pop);
      end
   end

   assign bus.WBFTOP_CfgRdy = w_cfg_rdy;
   assign bus.WBFGLB_DatRdy = w_dat_rdy;
   assign bus.WBFWCA_AdrRdy = w_adr_rdy;
   assign bus.WBFWCA_DatVld = w_dat_vld;
   assign bus.WBFWCA_Dat    = r_fifo[r_rp];

endmodule

// File: tb/tb_wbf_rd_buf.sv
// Randomized bench for wbf_rd_buf against a queue-based model of fill, read latency and ordering.
module tb_wbf_rd_buf;
   import wbf_pkg::*;

   logic clk;
   logic rst_n;

   wbf_rd_buf_if bus();

   wbf_rd_buf dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         t;
      logic [7:0] d;
   } exp_t;

   int         n_vec = 0;
   int         n_err = 0;
   bit         chk_en = 1'b0;
   int         cyc = 0;
   int         phase = 0;
   int         m_num = 0;
   int         m_wp = 0;
   logic [7:0] m_mem [256];
   exp_t       q[$];
   int         adr_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: updated on each observed handshake, checked once per cycle.
   always @(negedge clk) begin
      logic vld_exp;
      logic pop_exp;
      int   cn;
      int   a;
      if (chk_en && rst_n) begin
         vld_exp = (q.size() > 0) && (cyc >= q[0].t);
         pop_exp = vld_exp && bus.WCAWBF_DatRdy;
         chk("dat_vld", 32'(bus.WBFWCA_DatVld), 32'(vld_exp));
         chk("cfg_rdy", 32'(bus.WBFTOP_CfgRdy), 32'(phase == 0 || (phase == 2 && q.size() == 0)));
         chk("dat_rdy", 32'(bus.WBFGLB_DatRdy), 32'(phase == 1));
         chk("adr_rdy", 32'(bus.WBFWCA_AdrRdy), 32'(phase == 2 && (q.size() - int'(pop_exp)) < 2));
         if (bus.WBFWCA_DatVld && bus.WCAWBF_DatRdy) begin
            if (q.size() == 0) chk("dat_extra", 32'(bus.WBFWCA_DatVld), 32'(0));
            else begin
               chk("dat", 32'(bus.WBFWCA_Dat), 32'(q[0].d));
               void'(q.pop_front());
            end
         end
         if (bus.TOPWBF_CfgVld && bus.WBFTOP_CfgRdy) begin
            cn    = int'(bus.TOPWBF_CfgNum);
            m_num = (cn > 256) ? 256 : cn;
            m_wp  = 0;
            phase = (m_num == 0) ? 2 : 1;
         end else if (phase == 1 && bus.GLBWBF_DatVld && bus.WBFGLB_DatRdy) begin
            m_mem[m_wp] = bus.GLBWBF_Dat;
            m_wp++;
            if (m_wp == m_num) phase = 2;
         end
         if (bus.WCAWBF_AdrVld && bus.WBFWCA_AdrRdy) begin
            a = int'(bus.WCAWBF_Adr);
            q.push_back('{cyc + 2, (a < m_num) ? m_mem[a] : 8'h00});
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      chk_en = 1'b0;
      #1;
      chk("rst_cfg_rdy", 32'(bus.WBFTOP_CfgRdy), 32'(0));
      chk("rst_dat_rdy", 32'(bus.WBFGLB_DatRdy), 32'(0));
      chk("rst_adr_rdy", 32'(bus.WBFWCA_AdrRdy), 32'(0));
      chk("rst_dat_vld", 32'(bus.WBFWCA_DatVld), 32'(0));
      chk("rst_dat",     32'(bus.WBFWCA_Dat),    32'(0));
      q.delete();
      phase = 0;
      bus.TOPWBF_CfgVld = 1'b0;
      bus.GLBWBF_DatVld = 1'b0;
      bus.WCAWBF_AdrVld = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk_en = 1'b1;
   endtask

   task automatic do_cfg(input int num);
      int b;
      b = 0;
      bus.TOPWBF_CfgVld = 1'b1;
      bus.TOPWBF_CfgNum = 9'(num);
      @(negedge clk);
      while (!bus.WBFTOP_CfgRdy && b < 100) begin
         @(negedge clk);
         b++;
      end
      chk("cfg_timeout", 32'(b < 100), 32'(1));
      tick();
      bus.TOPWBF_CfgVld = 1'b0;
   endtask

   task automatic do_fill(input int n, input int vp, input bit fixed, input bit poke);
      int sent;
      int b;
      sent = 0;
      b    = 0;
      while (sent < n && b < 5000) begin
         bus.GLBWBF_DatVld = ($urandom_range(99) < vp);
         bus.GLBWBF_Dat    = fixed ? 8'(17 * (sent + 1)) : 8'($urandom);
         bus.WCAWBF_AdrVld = poke;
         bus.WCAWBF_Adr    = 8'($urandom);
         @(negedge clk);
         if (bus.GLBWBF_DatVld && bus.WBFGLB_DatRdy) sent++;
         tick();
         b++;
      end
      bus.GLBWBF_DatVld = 1'b0;
      bus.WCAWBF_AdrVld = 1'b0;
      chk("fill_count", 32'(sent), 32'(n));
   endtask

   // Issues n reads from adr_q; DatRdy is low for the first lo cycles, then high with probability rp%.
   task automatic do_reads(input int n, input int lo, input int rp, output int acc_lo, output int cycles);
      int acc;
      acc    = 0;
      acc_lo = 0;
      cycles = 0;
      while (acc < n && cycles < 500) begin
         bus.WCAWBF_AdrVld = 1'b1;
         bus.WCAWBF_Adr    = 8'(adr_q[0]);
         bus.WCAWBF_DatRdy = (cycles < lo) ? 1'b0 : ($urandom_range(99) < rp);
         @(negedge clk);
         if (bus.WBFWCA_AdrRdy) begin
            acc++;
            void'(adr_q.pop_front());
         end
         if (cycles < lo) acc_lo = acc;
         cycles++;
         tick();
      end
      bus.WCAWBF_AdrVld = 1'b0;
      chk("rd_count", 32'(acc), 32'(n));
   endtask

   task automatic drain();
      int b;
      b = 0;
      bus.WCAWBF_DatRdy = 1'b1;
      while (q.size() > 0 && b < 100) begin
         tick();
         b++;
      end
      tick();
      chk("drain", 32'(q.size()), 32'(0));
   endtask

   task automatic rand_reads(input int n);
      for (int i = 0; i < n; i++) adr_q.push_back(int'($urandom_range(255)));
   endtask

   int acc_lo;
   int cycles;

   initial begin
      rst_n             = 1'b1;
      bus.TOPWBF_CfgVld = 1'b0;
      bus.TOPWBF_CfgNum = '0;
      bus.GLBWBF_DatVld = 1'b0;
      bus.GLBWBF_Dat    = '0;
      bus.WCAWBF_AdrVld = 1'b0;
      bus.WCAWBF_Adr    = '0;
      bus.WCAWBF_DatRdy = 1'b1;
      #2;
      do_reset();
      tick();

      // Fill 0x11..0x44 then read 3,0,2
      do_cfg(4);
      do_fill(4, 70, 1'b1, 1'b0);
      adr_q = '{3, 0, 2};
      do_reads(3, 0, 100, acc_lo, cycles);
      drain();

      // Back-pressure: 6 reads, DatRdy low for 5 cycles
      rand_reads(6);
      do_reads(6, 5, 100, acc_lo, cycles);
      chk("bp_accepts", 32'(acc_lo), 32'(2));
      drain();

      // Throughput: 16 reads in 16 cycles
      rand_reads(16);
      do_reads(16, 0, 100, acc_lo, cycles);
      chk("thru_cycles", 32'(cycles), 32'(16));
      drain();

      // CfgNum=0 goes straight to WORK; all reads out of range
      do_cfg(0);
      tick();
      adr_q = '{0, 7};
      do_reads(2, 0, 100, acc_lo, cycles);
      drain();

      // Full depth, then oversize request clamped to depth
      do_cfg(256);
      do_fill(256, 90, 1'b0, 1'b0);
      rand_reads(40);
      do_reads(40, 0, 70, acc_lo, cycles);
      drain();
      do_cfg(511);
      do_fill(256, 100, 1'b0, 1'b0);
      adr_q = '{255, 0, 128};
      do_reads(3, 0, 100, acc_lo, cycles);
      drain();

      // Out-of-range read with num=4
      do_cfg(4);
      do_fill(4, 100, 1'b0, 1'b0);
      adr_q = '{5, 4, 3, 255};
      do_reads(4, 0, 60, acc_lo, cycles);
      drain();

      // Refill while a read is outstanding; AdrVld poked during FILL
      adr_q = '{1};
      do_reads(1, 100, 100, acc_lo, cycles);
      bus.WCAWBF_DatRdy = 1'b0;
      bus.TOPWBF_CfgNum = 9'(4);
      bus.TOPWBF_CfgVld = 1'b1;
      repeat (4) tick();
      bus.WCAWBF_DatRdy = 1'b1;
      do_cfg(4);
      do_fill(4, 60, 1'b0, 1'b1);
      drain();

      // Reset mid-FILL, then mid-read
      do_cfg(4);
      do_fill(2, 100, 1'b0, 1'b0);
      do_reset();
      repeat (2) tick();
      do_cfg(4);
      do_fill(4, 100, 1'b0, 1'b0);
      rand_reads(2);
      do_reads(2, 100, 100, acc_lo, cycles);
      do_reset();
      repeat (4) tick();

      // Random refills with random back-pressure
      for (int k = 0; k < 5; k++) begin
         int num;
         num = int'($urandom_range(256));
         do_cfg(num);
         do_fill(num, 75, 1'b0, 1'b0);
         rand_reads(20);
         do_reads(20, 0, 60, acc_lo, cycles);
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
